clk_div_bank: RTL and testbench

Multi-channel programmable clock-enable / slow-clock generator for the sys_clk domain. It generalises the fixed 1 Hz RTC toggle divider. Each channel has its own runtime-loadable divisor, output mode and enable. Divisor changes are glitch-free: a new setting takes effect only at a period boundary. A global sync restarts all channels phase-aligned. Outputs drive RTC inputs of the EMPU and slow peripheral strobes such as I2C/OLED refresh ticks.

---
 rtl/clk_div_bank_if.sv | 15 +
 rtl/clk_div_bank.sv | 74 +++++++
 tb/tb_clk_div_bank.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: configuration write channel of the clock divider bank.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 25
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_en;

    modport master (output cfg_valid, cfg_chan, cfg_div, cfg_mode, cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, cfg_chan, cfg_div, cfg_mode, cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock-enable / slow-clock generator
// with shadowed, boundary-applied reconfiguration and a phase-aligned global restart.
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 25,
    parameter int DEFAULT_DIV = 27_000_000
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    clk_div_bank_if.slave       cfg,
    input  logic                sync_all,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NSLOT = 1 << CH_W;

    logic [CHANNELS-1:0] pending;
    logic [NSLOT-1:0]    pend_slot;

    // Unpopulated channel addresses read as never-pending, so such writes are dropped
    assign pend_slot     = NSLOT'(pending);
    assign cfg.cfg_ready = !pend_slot[cfg.cfg_chan];

    for (genvar g = 0; g < CHANNELS; g++) begin : ch
        logic [DIV_W-1:0] cnt, div, div_sh, div_eff;
        logic             mode, en, mode_sh, en_sh, pend, co, tk;
        logic             term, acc, apply, restart;

        always_comb begin
            div_eff = (div == '0) ? DIV_W'(1) : div;
            term    = en && (cnt == div_eff - DIV_W'(1));
            acc     = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_chan == CH_W'(g));
            apply   = pend && (sync_all || term || !en);
            restart = apply && ((mode_sh != mode) || (en_sh && !en));
        end

        always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt     <= '0;
                co      <= 1'b0;
                tk      <= 1'b0;
                div     <= DIV_W'(DEFAULT_DIV);
                mode    <= 1'b0;
                en      <= 1'b1;
                div_sh  <= DIV_W'(DEFAULT_DIV);
                mode_sh <= 1'b0;
                en_sh   <= 1'b1;
                pend    <= 1'b0;
            end else begin
                cnt  <= (sync_all || !en || term || restart) ? '0 : cnt + DIV_W'(1);
                tk   <= !sync_all && term;
                // pulse mode: high only on terminal; toggle mode: flip on terminal
                co   <= (sync_all || !en || restart) ? 1'b0 :
                        term ? (mode | ~co) : (co & ~mode);
                pend <= acc | (pend & ~apply);
                if (apply) begin
                    div  <= div_sh;
                    mode <= mode_sh;
                    en   <= en_sh;
                end
                if (acc) begin
                    div_sh  <= cfg.cfg_div;
                    mode_sh <= cfg.cfg_mode;
                    en_sh   <= cfg.cfg_en;
                end
            end
        end

        assign clk_out[g] = co;
        assign tick[g]    = tk;
        assign pending[g] = pend;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed scoreboard bench; expected tick cycles are queued
// per channel and a negedge monitor matches every DUT tick against them.
module tb_clk_div_bank;
    logic       sys_clk = 0;
    logic       reset_n = 0;
    logic       sync_all = 0;
    logic [1:0] clk_out, tick;
    int         cyc, checks, passes;
    int         q0[$], q1[$];

    clk_div_bank_if #(.CH_W(1), .DIV_W(8)) cfg ();

    clk_div_bank #(.CHANNELS(2), .DIV_W(8), .DEFAULT_DIV(5)) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .cfg      (cfg),
        .sync_all (sync_all),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qhead(input int c);
        return (c == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int qpop(input int c);
        return (c == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic push_ticks(input int c, input int first, input int step, input int last);
        for (int t = first; t <= last; t += step)
            if (c == 0) q0.push_back(t);
            else q1.push_back(t);
    endtask

    // every observed tick must be the oldest expected one, at exactly that cycle
    always @(negedge sys_clk) begin
        if (reset_n)
            for (int c = 0; c < 2; c++) begin
                if (tick[c]) begin
                    if (qsize(c) == 0) chk($sformatf("tick_unexpected_ch%0d", c), cyc, -1);
                    else chk($sformatf("tick_ch%0d", c), cyc, qpop(c));
                end else if (qsize(c) != 0 && qhead(c) < cyc)
                    chk($sformatf("tick_missed_ch%0d", c), cyc, qpop(c));
            end
    end

    task automatic at(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    task automatic wr(input int ch, input int d, input bit m, input bit e, input bit exp_rdy);
        cfg.cfg_chan  = ch[0];
        cfg.cfg_div   = 8'(d);
        cfg.cfg_mode  = m;
        cfg.cfg_en    = e;
        cfg.cfg_valid = 1;
        #1 chk($sformatf("ready_ch%0d_c%0d", ch, cyc), int'(cfg.cfg_ready), int'(exp_rdy));
        @(negedge sys_clk);
        cfg.cfg_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg.cfg_valid = 0;
        cfg.cfg_chan  = 0;
        cfg.cfg_div   = 0;
        cfg.cfg_mode  = 0;
        cfg.cfg_en    = 0;
        repeat (3) @(negedge sys_clk);
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_ready", int'(cfg.cfg_ready), 1);
        push_ticks(0, 5, 5, 20);
        push_ticks(1, 5, 5, 35);
        reset_n = 1;
        at(4);  chk("clk_c4", int'(clk_out), 0);
        at(5);  chk("clk_c5", int'(clk_out), 3);
        at(9);  chk("clk_c9", int'(clk_out), 3);
        at(10); chk("clk_c10", int'(clk_out), 0);
        // shrink ch0 to 3 mid-period: old period completes at 20
        at(16);
        push_ticks(0, 23, 3, 35);
        wr(0, 3, 0, 1, 1);
        chk("ready_pend_c17", int'(cfg.cfg_ready), 0);
        at(19); chk("ready_pend_c19", int'(cfg.cfg_ready), 0);
        at(20); chk("ready_back_c20", int'(cfg.cfg_ready), 1);
        at(22); chk("ch0_clk_c22", int'(clk_out[0]), 0);
        at(23); chk("ch0_clk_c23", int'(clk_out[0]), 1);
        // backpressure on ch1; ch0 write lands on a terminal edge
        at(30);
        push_ticks(0, 39, 4, 51);
        push_ticks(1, 43, 8, 75);
        wr(1, 8, 0, 1, 1);
        wr(0, 4, 0, 1, 1);
        wr(1, 2, 0, 1, 0);
        // ch0 pulse mode div 4
        at(48);
        push_ticks(0, 55, 4, 67);
        wr(0, 4, 1, 1, 1);
        at(51); chk("pulse_restart_c51", int'(clk_out[0]), 0);
        for (int t = 52; t <= 63; t++) begin
            at(t);
            chk($sformatf("pulse_eq_tick_c%0d", t), int'(clk_out[0]), int'(tick[0]));
        end
        at(64);
        push_ticks(0, 68, 1, 72);
        wr(0, 0, 1, 1, 1);
        at(69); chk("div0_pulse_c69", int'(clk_out[0]), 1);
        // div 3 and 7, then phase-aligned restart
        at(70);
        push_ticks(0, 75, 3, 81);
        push_ticks(1, 82, 1, 82);
        wr(0, 3, 0, 1, 1);
        wr(1, 7, 0, 1, 1);
        at(82);
        chk("pre_sync_clk", int'(clk_out), 3);
        push_ticks(0, 86, 3, 122);
        push_ticks(1, 90, 7, 111);
        sync_all = 1;
        @(negedge sys_clk);
        sync_all = 0;
        chk("sync_clk", int'(clk_out), 0);
        chk("sync_tick", int'(tick), 0);
        at(104); chk("sync_coincide_c104", int'(tick), 3);
        // disable ch1 (applies at its boundary), then re-enable while disabled
        at(105);
        wr(1, 7, 0, 0, 1);
        at(112); chk("dis_clk_c112", int'(clk_out[1]), 0);
        at(113); chk("dis_clk_c113", int'(clk_out[1]), 0);
        at(114);
        push_ticks(1, 118, 2, 122);
        wr(1, 2, 0, 1, 1);
        chk("reen_ready_c115", int'(cfg.cfg_ready), 0);
        at(116);
        chk("reen_ready_c116", int'(cfg.cfg_ready), 1);
        chk("reen_clk_c116", int'(clk_out[1]), 0);
        // async reset with a write pending
        at(122);
        wr(0, 9, 0, 1, 1);
        chk("pend_ready_c123", int'(cfg.cfg_ready), 0);
        chk("pre_rst_clk", int'(clk_out), 3);
        #2 reset_n = 0;
        #1;
        chk("async_rst_clk", int'(clk_out), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_ready", int'(cfg.cfg_ready), 1);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        @(negedge sys_clk);
        push_ticks(0, 5, 5, 10);
        push_ticks(1, 5, 5, 10);
        reset_n = 1;
        at(5); chk("rst2_clk_c5", int'(clk_out), 3);
        at(12);
        chk("q0_final", q0.size(), 0);
        chk("q1_final", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
